// File: rtl/prio_arbiter_rr_if.sv
// prio_arbiter_rr_if: request/grant bundle for prio_arbiter_rr.
// master = requester side, slave = arbiter side.
// Signals: req_i, prio_i, done_i (to arbiter);
// gnt_valid_o, gnt_o, sel_o, prio_o (from arbiter).
interface prio_arbiter_rr_if #(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3
);
  localparam int SW = $clog2(N);

  logic [N-1:0]           req_i;
  logic [N*PRIO_BITS-1:0] prio_i;
  logic                   done_i;
  logic                   gnt_valid_o;
  logic [N-1:0]           gnt_o;
  logic [SW-1:0]          sel_o;
  logic [PRIO_BITS-1:0]   prio_o;

  modport master (
    output req_i,
    output prio_i,
    output done_i,
    input  gnt_valid_o,
    input  gnt_o,
    input  sel_o,
    input  prio_o
  );

  modport slave (
    input  req_i,
    input  prio_i,
    input  done_i,
    output gnt_valid_o,
    output gnt_o,
    output sel_o,
    output prio_o
  );
endinterface

// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr: clocked priority arbiter with
// round-robin tie break and grant hold until done.
// Ports: clk_i, rst_n_i (async, active-low),
// bus (prio_arbiter_rr_if.slave): req_i, prio_i,
// done_i in; gnt_valid_o, gnt_o, sel_o, prio_o out.
// Priority 0 is highest. Optional ARB_AGING_EN
// boosts sources that lose AGE_LIMIT arbitrations.
module prio_arbiter_rr #(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3,
  parameter int AGE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  prio_arbiter_rr_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int IW = SW + 1;
  localparam logic [SW-1:0] LAST = SW'(N - 1);
  localparam logic [IW-1:0] N_W  = IW'(N);
  localparam logic [N-1:0]  ONE  = N'(1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  typedef logic [PRIO_BITS-1:0] prio_t;

  state_t        state_q, state_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] rr_q, rr_d;
  prio_t         prio_q, prio_d;

  prio_t         prio_raw [N];
  prio_t         prio_eff [N];
  logic [N-1:0]  elig;
  prio_t         min_p;
  logic [IW-1:0] scan;
  logic [SW-1:0] win_idx;
  logic          win_found;
  logic          take;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      prio_raw[k] = bus.prio_i[k*PRIO_BITS +: PRIO_BITS];
    end
  end

`ifdef ARB_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

  logic [AW-1:0] age_q [N];

  // Counts arbitrations lost while requesting;
  // saturates at AGE_MAX.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < N; k++) begin
        age_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!bus.req_i[k] ||
            (take && win_idx == SW'(k))) begin
          age_q[k] <= '0;
        end else if (take && elig[k] &&
                     age_q[k] < AGE_MAX) begin
          age_q[k] <= age_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      prio_eff[k] = (age_q[k] >= AGE_MAX) ?
                    '0 : prio_raw[k];
    end
  end
`else
  logic unused_age;
  assign unused_age = ^AGE_LIMIT;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      prio_eff[k] = prio_raw[k];
    end
  end
`endif

  // The grantee is excluded on re-arbitration so a
  // done_i hands off to someone else.
  assign elig = (state_q == GRANT) ?
                (bus.req_i & ~gnt_q) : bus.req_i;

  always_comb begin
    min_p = '1;
    for (int k = 0; k < N; k++) begin
      if (elig[k] && prio_eff[k] < min_p) begin
        min_p = prio_eff[k];
      end
    end
  end

  // Scan upward from rr_q with wrap; first
  // eligible source at min_p wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 0; i < N; i++) begin
      scan = {1'b0, rr_q} + IW'(i);
      if (scan >= N_W) begin
        scan = scan - N_W;
      end
      if (!win_found &&
          elig[scan[SW-1:0]] &&
          prio_eff[scan[SW-1:0]] == min_p) begin
        win_found = 1'b1;
        win_idx   = scan[SW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    rr_d    = rr_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        take = win_found;
      end
      GRANT: begin
        // done_i outranks a simultaneous req drop.
        if (bus.done_i) begin
          if (win_found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            gnt_d   = '0;
          end
        end else if (!bus.req_i[sel_q]) begin
          state_d = IDLE;
          valid_d = 1'b0;
          gnt_d   = '0;
        end
      end
    endcase
    if (take) begin
      state_d = GRANT;
      valid_d = 1'b1;
      gnt_d   = ONE << win_idx;
      sel_d   = win_idx;
      prio_d  = prio_raw[win_idx];
      rr_d    = (win_idx == LAST) ?
                '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      gnt_q   <= '0;
      sel_q   <= '0;
      prio_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.gnt_valid_o = valid_q;
  assign bus.gnt_o       = gnt_q;
  assign bus.sel_o       = sel_q;
  assign bus.prio_o      = prio_q;
endmodule

// File: tb/tb_prio_arbiter_rr.sv
// tb_prio_arbiter_rr: directed vector bench for
// prio_arbiter_rr (N=8, PRIO_BITS=3, AGE_LIMIT=2).
module tb_prio_arbiter_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  prio_arbiter_rr_if #(.N(8), .PRIO_BITS(3)) bus ();

  prio_arbiter_rr #(
    .N(8),
    .PRIO_BITS(3),
    .AGE_LIMIT(2)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  req;
    logic [23:0] prio;
    logic        done;
    logic        v;
    logic [7:0]  g;
    logic [2:0]  s;
    logic [2:0]  p;
  } vec_t;

  vec_t vt[$];

  function automatic logic [23:0] setp(
    input logic [23:0] b,
    input int k,
    input logic [2:0] val
  );
    logic [23:0] r;
    r = b;
    r[k*3 +: 3] = val;
    return r;
  endfunction

  function automatic vec_t mk(
    input logic [7:0] req, input logic [23:0] pr,
    input logic d, input logic v,
    input logic [7:0] g, input logic [2:0] s,
    input logic [2:0] p
  );
    vec_t r;
    r.req = req; r.prio = pr; r.done = d;
    r.v = v; r.g = g; r.s = s; r.p = p;
    return r;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_out(
    input string tag, input logic v,
    input logic [7:0] g, input logic [2:0] s,
    input logic [2:0] p
  );
    chk({tag, ".valid"}, 32'(bus.gnt_valid_o), 32'(v));
    chk({tag, ".gnt"}, 32'(bus.gnt_o), 32'(g));
    chk({tag, ".sel"}, 32'(bus.sel_o), 32'(s));
    chk({tag, ".prio"}, 32'(bus.prio_o), 32'(p));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] p3, pa, pb, pw, pg;
    p3 = {8{3'd3}};
    pa = setp(setp(p3, 2, 3'd5), 5, 3'd1);
    pb = setp(pa, 5, 3'd7);
    pw = setp(setp(p3, 0, 3'd2), 1, 3'd2);
    pg = setp(setp(setp(p3, 0, 3'd0), 1, 3'd0), 7, 3'd7);

    vt.push_back(mk(8'h0F, p3, 0, 1, 8'h01, 0, 3));
    vt.push_back(mk(8'h0F, p3, 1, 1, 8'h02, 1, 3));
    vt.push_back(mk(8'h0F, p3, 1, 1, 8'h04, 2, 3));
    vt.push_back(mk(8'h0F, p3, 1, 1, 8'h08, 3, 3));
    vt.push_back(mk(8'h0F, p3, 1, 1, 8'h01, 0, 3));
    vt.push_back(mk(8'h01, p3, 1, 0, 8'h00, 0, 3));
    vt.push_back(mk(8'h24, pa, 0, 1, 8'h20, 5, 1));
    vt.push_back(mk(8'h24, pb, 0, 1, 8'h20, 5, 1));
    vt.push_back(mk(8'h24, pb, 1, 1, 8'h04, 2, 5));
    vt.push_back(mk(8'h00, pb, 0, 0, 8'h00, 2, 5));
    vt.push_back(mk(8'h00, pb, 1, 0, 8'h00, 2, 5));
    vt.push_back(mk(8'h10, p3, 0, 1, 8'h10, 4, 3));
    vt.push_back(mk(8'h00, p3, 0, 0, 8'h00, 4, 3));
    vt.push_back(mk(8'hFF, p3, 0, 1, 8'h20, 5, 3));
    vt.push_back(mk(8'hDF, p3, 1, 1, 8'h40, 6, 3));
    vt.push_back(mk(8'hDF, p3, 0, 1, 8'h40, 6, 3));
    vt.push_back(mk(8'h03, pw, 1, 1, 8'h01, 0, 2));
    vt.push_back(mk(8'h03, pw, 1, 1, 8'h02, 1, 2));
    vt.push_back(mk(8'h00, pw, 1, 0, 8'h00, 1, 2));

    bus.req_i  = 8'hFF;
    bus.prio_i = '0;
    bus.done_i = 1'b0;
    step();
    step();
    chk_out("reset", 0, 8'h00, 0, 0);

    rst_n = 1'b1;
    foreach (vt[i]) begin
      bus.req_i  = vt[i].req;
      bus.prio_i = vt[i].prio;
      bus.done_i = vt[i].done;
      step();
      chk_out($sformatf("v%0d", i),
              vt[i].v, vt[i].g, vt[i].s, vt[i].p);
    end

    // Async reset between edges.
    bus.req_i  = 8'h01;
    bus.prio_i = p3;
    bus.done_i = 1'b0;
    step();
    chk_out("pre_arst", 1, 8'h01, 0, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 0, 8'h00, 0, 0);
    step();
    rst_n = 1'b1;

    // Aging: 0 and 1 at prio 0, 7 at prio 7.
    bus.req_i  = 8'h83;
    bus.prio_i = pg;
    bus.done_i = 1'b0;
    step();
    chk_out("age1", 1, 8'h01, 0, 0);
    bus.done_i = 1'b1;
    step();
    chk_out("age2", 1, 8'h02, 1, 0);
    step();
`ifdef ARB_AGING_EN
    chk_out("age3", 1, 8'h80, 7, 7);
`else
    chk_out("age3", 1, 8'h01, 0, 0);
`endif
    bus.req_i = 8'h00;
    step();
    chk("age_end.valid", 32'(bus.gnt_valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
